// File: rtl/adder_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : adder_bist_ctrl_if
// Purpose  : Bundles the command, adder-facing and status signals of the
//            8-bit adder BIST controller.
//            master : test host and adder model (drives start/abort/seed/
//                     num_vectors and the adder sum, observes everything else)
//            slave  : the BIST controller itself
// Ports    : start, abort, seed[15:0], num_vectors[15:0]   (command)
//            a_out[7:0], b_out[7:0], sum_in[7:0]            (adder side)
//            busy, done, pass, err_count, vec_count,
//            signature, fail_a, fail_b, fail_sum            (status)
// Revision : 1.0 - initial release
// ============================================================================
interface adder_bist_ctrl_if;
    logic        start;
    logic        abort;
    logic [15:0] seed;
    logic [15:0] num_vectors;
    logic [7:0]  a_out;
    logic [7:0]  b_out;
    logic [7:0]  sum_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] vec_count;
    logic [15:0] signature;
    logic [7:0]  fail_a;
    logic [7:0]  fail_b;
    logic [7:0]  fail_sum;

    modport master (
        output start, abort, seed, num_vectors, sum_in,
        input  a_out, b_out, busy, done, pass, err_count, vec_count,
               signature, fail_a, fail_b, fail_sum
    );

    modport slave (
        input  start, abort, seed, num_vectors, sum_in,
        output a_out, b_out, busy, done, pass, err_count, vec_count,
               signature, fail_a, fail_b, fail_sum
    );
endinterface
`default_nettype wire

// File: rtl/adder_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_bist_ctrl
// Purpose  : Built-in self-test controller for an 8-bit combinational adder.
//            An LFSR produces operand pairs that are registered onto the
//            adder inputs; after SETTLE_CYCLES the adder sum is sampled,
//            compared against a golden add, folded into a MISR, and error
//            status (count, first failing vector) is accumulated.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - adder_bist_ctrl_if.slave (command, adder, status)
// Revision : 1.0 - initial release
// ============================================================================
module adder_bist_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [15:0] DEFAULT_SEED  = 16'hACE1
) (
    input wire               clk,
    input wire               rst_n,
    adder_bist_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_num_vectors;
    logic [15:0] r_lfsr;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [3:0]  r_settle_cnt;
    logic [15:0] r_err_count;
    logic [15:0] r_vec_count;
    logic [15:0] r_signature;
    logic [7:0]  r_fail_a;
    logic [7:0]  r_fail_b;
    logic [7:0]  r_fail_sum;
    logic        r_failed;

    logic        w_load;
    logic        w_apply;
    logic        w_check;
    logic [15:0] w_load_seed;
    logic [15:0] w_lfsr_next;
    logic [15:0] w_sig_next;
    logic [15:0] w_vec_inc;
    logic [7:0]  w_golden;
    logic        w_mismatch;

    assign w_load_seed = (bus.seed == 16'd0) ? DEFAULT_SEED : bus.seed;
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_sig_next  = {r_signature[14:0],
                          r_signature[15] ^ r_signature[13] ^ r_signature[12] ^ r_signature[10]}
                         ^ {8'h00, bus.sum_in};
    assign w_vec_inc   = r_vec_count + 16'd1;
    // Carry-out is intentionally dropped: the macro under test is 8 bits wide.
    assign w_golden    = r_a + r_b;
    assign w_mismatch  = (bus.sum_in != w_golden);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and datapath strobes. abort outranks every other transition,
    // and an aborted APPLY/CHECK raises no strobe so all status is frozen.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_apply      = 1'b0;
        w_check      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = (bus.num_vectors == 16'd0) ? S_DONE : S_APPLY;
                end
            end
            S_APPLY: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_apply      = 1'b1;
                    w_next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else if (r_settle_cnt == c_settle_last) begin
                    w_next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_check      = 1'b1;
                    w_next_state = (w_vec_inc == r_num_vectors) ? S_DONE : S_APPLY;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand generation, settle timing, checking and status.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_vectors <= 16'd0;
            r_lfsr        <= 16'd0;
            r_a           <= 8'd0;
            r_b           <= 8'd0;
            r_settle_cnt  <= 4'd0;
            r_err_count   <= 16'd0;
            r_vec_count   <= 16'd0;
            r_signature   <= 16'd0;
            r_fail_a      <= 8'd0;
            r_fail_b      <= 8'd0;
            r_fail_sum    <= 8'd0;
            r_failed      <= 1'b0;
        end else begin
            // Operands are not cleared on start: they hold the last applied pair.
            if (w_load) begin
                r_num_vectors <= bus.num_vectors;
                r_lfsr        <= w_load_seed;
                r_err_count   <= 16'd0;
                r_vec_count   <= 16'd0;
                r_signature   <= 16'd0;
                r_fail_a      <= 8'd0;
                r_fail_b      <= 8'd0;
                r_fail_sum    <= 8'd0;
                r_failed      <= 1'b0;
            end

            if (w_apply) begin
                r_a          <= r_lfsr[15:8];
                r_b          <= r_lfsr[7:0];
                r_lfsr       <= w_lfsr_next;
                r_settle_cnt <= 4'd0;
            end else if (r_state == S_SETTLE) begin
                r_settle_cnt <= r_settle_cnt + 4'd1;
            end

            if (w_check) begin
                r_signature <= w_sig_next;
                r_vec_count <= w_vec_inc;
                if (w_mismatch) begin
                    if (r_err_count != 16'hFFFF) begin
                        r_err_count <= r_err_count + 16'd1;
                    end
                    if (!r_failed) begin
                        r_failed   <= 1'b1;
                        r_fail_a   <= r_a;
                        r_fail_b   <= r_b;
                        r_fail_sum <= bus.sum_in;
                    end
                end
            end
        end
    end

    assign bus.a_out     = r_a;
    assign bus.b_out     = r_b;
    assign bus.busy      = (r_state == S_APPLY) || (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign bus.done      = (r_state == S_DONE);
    assign bus.pass      = (r_state == S_DONE) && (r_err_count == 16'd0);
    assign bus.err_count = r_err_count;
    assign bus.vec_count = r_vec_count;
    assign bus.signature = r_signature;
    assign bus.fail_a    = r_fail_a;
    assign bus.fail_b    = r_fail_b;
    assign bus.fail_sum  = r_fail_sum;

endmodule
`default_nettype wire

// File: tb/tb_adder_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_bist_ctrl
// Purpose  : Self-checking bench for adder_bist_ctrl. A bench adder (with
//            selectable faults) closes the loop; a run-level reference model
//            predicts every output from the cycle offset since start was
//            accepted, and a compare process checks it on every falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_bist_ctrl;
    localparam int unsigned S    = 1;
    localparam int          P    = S + 2;   // vector period in cycles
    localparam int          MAXV = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   fault_mode = 0;
    int   checks = 0;
    int   errors = 0;

    adder_bist_ctrl_if bus();

    adder_bist_ctrl #(
        .SETTLE_CYCLES (S),
        .DEFAULT_SEED  (16'hACE1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- bench adder with optional faults ----------------
    function automatic logic [7:0] bench_sum(input logic [7:0] a, input logic [7:0] b, input int fm);
        logic [7:0] s;
        s = a + b;
        case (fm)
            1: s[0] = 1'b0;
            2: if (a[2:0] == 3'b101) s[7] = ~s[7];
            3: s[4] = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

    always_comb bus.sum_in = bench_sum(bus.a_out, bus.b_out, fault_mode);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] err;
        logic [15:0] vec;
        logic [15:0] sig;
        logic [7:0]  fa;
        logic [7:0]  fb;
        logic [7:0]  fs;
    } exp_t;

    logic [7:0]  m_op_a [MAXV];
    logic [7:0]  m_op_b [MAXV];
    logic [7:0]  m_obs  [MAXV];
    logic [15:0] m_err_p [MAXV+1];
    logic [15:0] m_sig_p [MAXV+1];
    int          m_first_fail = -1;
    int          m_n = 0;
    int          m_e0 = 0;
    int          m_j_abort = 0;
    int          m_cyc = 0;
    bit          m_have_run = 1'b0;
    bit          m_aborted = 1'b0;
    logic [7:0]  m_base_a = 8'd0;
    logic [7:0]  m_base_b = 8'd0;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    function automatic void build_run(input logic [15:0] s, input int nv, input int fm);
        logic [15:0] q;
        logic [15:0] sig;
        logic [7:0]  g;
        int          e;
        q   = (s == 16'd0) ? 16'hACE1 : s;
        sig = 16'd0;
        e   = 0;
        m_first_fail = -1;
        m_err_p[0] = 16'd0;
        m_sig_p[0] = 16'd0;
        for (int i = 0; i < nv; i++) begin
            m_op_a[i] = q[15:8];
            m_op_b[i] = q[7:0];
            m_obs[i]  = bench_sum(q[15:8], q[7:0], fm);
            q   = lfsr_step(q);
            sig = lfsr_step(sig) ^ {8'h00, m_obs[i]};
            g   = m_op_a[i] + m_op_b[i];
            if (m_obs[i] != g) begin
                e = e + 1;
                if (m_first_fail < 0) m_first_fail = i;
            end
            m_err_p[i+1] = 16'(e);
            m_sig_p[i+1] = sig;
        end
        m_n = nv;
    endfunction

    // Expected outputs right now, from the number of edges since start was taken.
    function automatic exp_t model_now();
        exp_t e;
        int   j;
        int   applied;
        int   checked;
        bit   idle;
        e = '0;
        if (!m_have_run) return e;
        j    = m_cyc - m_e0;
        idle = 1'b0;
        if (m_aborted && j >= m_j_abort) begin
            j    = m_j_abort - 1;
            idle = 1'b1;
        end
        applied = (j >= 1) ? ((j - 1) / P + 1) : 0;
        if (applied > m_n) applied = m_n;
        checked = j / P;
        if (checked > m_n) checked = m_n;
        e.busy = !idle && (j < m_n * P);
        e.done = !idle && (j >= m_n * P);
        e.a    = (applied == 0) ? m_base_a : m_op_a[applied-1];
        e.b    = (applied == 0) ? m_base_b : m_op_b[applied-1];
        e.err  = m_err_p[checked];
        e.vec  = 16'(checked);
        e.sig  = m_sig_p[checked];
        if (m_first_fail >= 0 && m_first_fail < checked) begin
            e.fa = m_op_a[m_first_fail];
            e.fb = m_op_b[m_first_fail];
            e.fs = m_obs[m_first_fail];
        end
        e.pass = e.done && (e.err == 16'd0);
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin : p_model
        exp_t cur;
        if (!rst_n) begin
            m_have_run = 1'b0;
            m_aborted  = 1'b0;
            m_cyc      = 0;
        end else begin
            cur = model_now();
            if (bus.abort) begin
                if (cur.busy || cur.done) begin
                    m_aborted = 1'b1;
                    m_j_abort = m_cyc + 1 - m_e0;
                end
            end else if (bus.start && !cur.busy) begin
                m_base_a = cur.a;
                m_base_b = cur.b;
                build_run(bus.seed, int'(bus.num_vectors), fault_mode);
                m_e0       = m_cyc + 1;
                m_aborted  = 1'b0;
                m_have_run = 1'b1;
            end
            m_cyc = m_cyc + 1;
        end
    end

    always @(negedge clk) begin : p_compare
        exp_t e;
        if (rst_n) begin
            e = model_now();
            chk("busy",      32'(bus.busy),      32'(e.busy));
            chk("done",      32'(bus.done),      32'(e.done));
            chk("pass",      32'(bus.pass),      32'(e.pass));
            chk("a_out",     32'(bus.a_out),     32'(e.a));
            chk("b_out",     32'(bus.b_out),     32'(e.b));
            chk("err_count", 32'(bus.err_count), 32'(e.err));
            chk("vec_count", 32'(bus.vec_count), 32'(e.vec));
            chk("signature", 32'(bus.signature), 32'(e.sig));
            chk("fail_a",    32'(bus.fail_a),    32'(e.fa));
            chk("fail_b",    32'(bus.fail_b),    32'(e.fb));
            chk("fail_sum",  32'(bus.fail_sum),  32'(e.fs));
        end
    end

    // ---------------- stimulus ----------------
    // Drives start after a rising edge so the following edge samples it;
    // returns at the falling edge after that sampling edge.
    task automatic start_run(input logic [15:0] s, input logic [15:0] n);
        @(negedge clk);
        bus.seed        = s;
        bus.num_vectors = n;
        bus.start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!bus.done && k < budget) begin
            @(negedge clk);
            k = k + 1;
        end
        chk("done_reached", 32'(bus.done), 32'd1);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.seed        = 16'd0;
        bus.num_vectors = 16'd0;
        rst_n           = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_a_out",     32'(bus.a_out),     32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_signature", 32'(bus.signature), 32'd0);
        rst_n = 1'b1;

        // Zero vectors: straight to DONE.
        start_run(16'h0000, 16'd0);
        chk("nv0_done",  32'(bus.done),      32'd1);
        chk("nv0_pass",  32'(bus.pass),      32'd1);
        chk("nv0_vec",   32'(bus.vec_count), 32'd0);
        chk("nv0_a_out", 32'(bus.a_out),     32'd0);
        chk("nv0_b_out", 32'(bus.b_out),     32'd0);

        // One vector from the default seed, with exact done timing.
        start_run(16'h0000, 16'd1);
        @(negedge clk);
        @(negedge clk);
        chk("run1_done_edge3", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("run1_done_edge4", 32'(bus.done),      32'd1);
        chk("run1_a_out",      32'(bus.a_out),     32'hAC);
        chk("run1_b_out",      32'(bus.b_out),     32'hE1);
        chk("run1_pass",       32'(bus.pass),      32'd1);
        chk("run1_vec",        32'(bus.vec_count), 32'd1);
        chk("run1_sig",        32'(bus.signature), 32'h008D);

        // Two vectors, fault free.
        start_run(16'h0000, 16'd2);
        wait_done(40);
        chk("run2_a_out", 32'(bus.a_out),     32'h59);
        chk("run2_b_out", 32'(bus.b_out),     32'hC3);
        chk("run2_vec",   32'(bus.vec_count), 32'd2);
        chk("run2_pass",  32'(bus.pass),      32'd1);
        chk("run2_sig",   32'(bus.signature), 32'h0106);

        // Two vectors with sum[0] stuck-at-0.
        fault_mode = 1;
        start_run(16'h0000, 16'd2);
        wait_done(40);
        chk("sa0_err",      32'(bus.err_count), 32'd1);
        chk("sa0_fail_a",   32'(bus.fail_a),    32'hAC);
        chk("sa0_fail_b",   32'(bus.fail_b),    32'hE1);
        chk("sa0_fail_sum", 32'(bus.fail_sum),  32'h8C);
        chk("sa0_pass",     32'(bus.pass),      32'd0);
        chk("sa0_sig",      32'(bus.signature), 32'h0104);
        fault_mode = 0;

        // Abort in SETTLE of vector 3 of 10, with ignored starts beforehand.
        start_run(16'h0000, 16'd10);
        for (int k = 1; k <= 8; k++) begin
            bus.start = (k == 3) || (k == 5);
            bus.seed  = 16'h5555;
            bus.abort = (k == 8);
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            bus.abort = 1'b0;
        end
        chk("abort_busy",  32'(bus.busy),      32'd0);
        chk("abort_done",  32'(bus.done),      32'd0);
        chk("abort_vec",   32'(bus.vec_count), 32'd2);
        chk("abort_a_out", 32'(bus.a_out),     32'hB3);
        chk("abort_b_out", 32'(bus.b_out),     32'h87);

        // start and abort together while idle: stays idle.
        bus.start       = 1'b1;
        bus.abort       = 1'b1;
        bus.num_vectors = 16'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("startabort_busy", 32'(bus.busy),      32'd0);
        chk("startabort_vec",  32'(bus.vec_count), 32'd2);

        // Asynchronous reset in the middle of a run.
        start_run(16'h1234, 16'd20);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_a_out", 32'(bus.a_out),     32'd0);
        chk("midrst_b_out", 32'(bus.b_out),     32'd0);
        chk("midrst_vec",   32'(bus.vec_count), 32'd0);
        chk("midrst_busy",  32'(bus.busy),      32'd0);
        #1 rst_n = 1'b1;
        start_run(16'h1234, 16'd1);
        wait_done(40);
        chk("seed1234_a_out", 32'(bus.a_out), 32'h12);
        chk("seed1234_b_out", 32'(bus.b_out), 32'h34);
        chk("seed1234_pass",  32'(bus.pass),  32'd1);

        // Randomized runs: seeds, lengths, faults, stray starts and aborts.
        for (int r = 0; r < 30; r++) begin
            logic [15:0] s;
            int          n;
            bit          do_ab;
            int          ab_at;
            fault_mode = int'($urandom_range(0, 3));
            s     = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            n     = int'($urandom_range(0, 30));
            do_ab = (n > 0) && ($urandom_range(0, 3) == 0);
            ab_at = (n > 0) ? int'($urandom_range(1, n * P)) : 0;
            start_run(s, 16'(n));
            for (int k = 1; k <= n * P + 1; k++) begin
                bus.start       = (k < n * P) && ($urandom_range(0, 5) == 0);
                bus.seed        = 16'($urandom);
                bus.num_vectors = 16'($urandom_range(0, 30));
                bus.abort       = do_ab && (k == ab_at);
                @(posedge clk);
                @(negedge clk);
                bus.start = 1'b0;
                bus.abort = 1'b0;
                if (do_ab && k == ab_at) break;
            end
            if ($urandom_range(0, 4) == 0) begin
                bus.abort = 1'b1;
                bus.start = 1'($urandom_range(0, 1));
                @(posedge clk);
                @(negedge clk);
                bus.start = 1'b0;
                bus.abort = 1'b0;
            end
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
